// File: rtl/req_gnt_pkg.sv
// Shared types and default sizing for the request/grant arbiter.
package req_gnt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/req_gnt_arbiter_rr_pick.sv
// Combinational round-robin picker: first qualifying index after last_i, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] qual_i,
  input  logic [IW-1:0]    last_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             pick_valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    pick_o       = '0;
    pick_valid_o = 1'b0;
    idx          = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last_i) + k) % N_REQ);
      if (!pick_valid_o && qual_i[idx]) begin
        pick_o[idx]  = 1'b1;
        pick_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_gnt_arbiter.sv
// Round-robin request/grant arbiter with registered one-hot grant pulse and
// sticky per-requester starvation flags.
//   state | meaning
//   IDLE  | no grant driven this cycle
//   GRANT | one-hot gnt pulse driven this cycle
module req_gnt_arbiter
  import req_gnt_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_en,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [N_REQ-1:0] starve,
  output logic             starve_any
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q [N_REQ];
  logic [CW-1:0]    cnt_d [N_REQ];
  logic [N_REQ-1:0] starve_q, starve_d;

  logic [N_REQ-1:0] qual;
  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic             do_grant;

  // A requester being granted right now is not eligible again this cycle.
  assign qual     = req & ~gnt_q;
  assign do_grant = gnt_en && pick_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .qual_i       (qual),
    .last_i       (last_q),
    .pick_o       (pick),
    .pick_valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    last_d  = last_q;
    case (state_q)
      IDLE:  if (do_grant)  state_d = GRANT;
      GRANT: if (!do_grant) state_d = IDLE;
    endcase
    if (do_grant) begin
      gnt_d = pick;
      for (int i = 0; i < N_REQ; i++) begin
        if (pick[i]) last_d = IW'(i);
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = '0;
      if (req[i] && !gnt_q[i]) begin
        if (cnt_q[i] == CW'(MAX_WAIT)) begin
          starve_d[i] = 1'b1;
          cnt_d[i]    = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      last_q   <= IW'(N_REQ - 1);
      starve_q <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      starve_q <= starve_d;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign gnt        = gnt_q;
  assign gnt_valid  = |gnt_q;
  assign starve     = starve_q;
  assign starve_any = |starve_q;

endmodule

// File: doc/req_gnt_arbiter.md
REQ_GNT_ARBITER -- requirements
Module: req_gnt_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter MAX_WAIT, default 4: wait-cycle limit per requester, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, N_REQ: level requests, one bit per requester.
REQ-006 SHALL have port gnt_en, input, 1: grant enable; low stalls all grants.
REQ-007 SHALL have port gnt, output, N_REQ: registered one-hot grant pulse, one cycle wide.
REQ-008 SHALL have port gnt_valid, output, 1: equals OR of gnt.
REQ-009 SHALL have port starve, output, N_REQ: sticky per-requester wait-limit violation flags.
REQ-010 SHALL have port starve_any, output, 1: equals OR of starve.

Function
REQ-011 SHALL sample req and gnt_en each cycle and drive gnt registered, one cycle after the sample (latency 1).
REQ-012 SHALL assert at most one gnt bit per cycle; gnt SHALL never be asserted for a requester whose req was low in the sampled cycle.
REQ-013 SHALL implement FSM with states IDLE (no grant this cycle) and GRANT (gnt pulse driven).
REQ-014 SHALL transition IDLE->GRANT when gnt_en=1 and any req bit qualifies, else stay IDLE.
REQ-015 SHALL transition GRANT->GRANT on back-to-back qualifying requests, GRANT->IDLE otherwise.
REQ-016 SHALL treat req[i] as not qualifying in the cycle gnt[i]=1, so a held req is re-granted no earlier than 2 cycles after the previous grant to i.
REQ-017 SHALL select among qualifying requesters by round-robin: search starts at index (last_granted+1) mod N_REQ, wrapping from N_REQ-1 to 0.
REQ-018 SHALL hold last_granted unchanged in cycles without a grant.
REQ-019 SHALL keep per-requester wait counter cnt[i], width clog2(MAX_WAIT+1): +1 when req[i]=1 and gnt[i]=0; cleared when gnt[i]=1 or req[i]=0; saturates at MAX_WAIT.
REQ-020 SHALL set starve[i] when cnt[i]==MAX_WAIT and req[i]=1 and gnt[i]=0 in the same cycle; starve[i] SHALL remain set until reset.
REQ-021 SHALL guarantee starve stays 0 for all legal req patterns with gnt_en held 1 and MAX_WAIT>=N_REQ.
REQ-022 SHALL, with gnt_en=0, issue no grant yet continue counting waits and setting starve.
REQ-023 SHALL treat req=0 in all bits as IDLE with no counter growth.

Reset
REQ-024 SHALL on reset=1 clear gnt, gnt_valid, starve, starve_any, all cnt[i], set FSM to IDLE and last_granted to N_REQ-1 (first search starts at 0).
REQ-025 SHALL let reset override every other input in the same cycle, including mid-grant; gnt SHALL be 0 in the cycle after reset is sampled high.
REQ-026 SHALL resume arbitration on the first cycle reset is sampled low, with req sampled in that cycle.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, GRANT) and default N_REQ/MAX_WAIT constants in shared package req_gnt_pkg.
REQ-028 SHALL contain one sub-module rr_pick: combinational round-robin picker (inputs qualifying mask, last_granted index; outputs one-hot pick, pick_valid).
REQ-029 SHALL keep all state (FSM, last_granted, cnt, starve, gnt) in req_gnt_arbiter.

Verification
REQ-030 SHALL test single requester: req=4'b0001 from cycle 0 held -> gnt=4'b0001 at cycles 1,3,5 (every 2 cycles), starve=0.
REQ-031 SHALL test all request: req=4'b1111 held -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, starve=0.
REQ-032 SHALL test wrap/fairness: last grant index 3, req=4'b1001 -> next gnt=4'b0001, then 4'b1000.
REQ-033 SHALL test stall: req=4'b0010, gnt_en=0 for 5 cycles -> starve=4'b0010 and starve_any=1 on the MAX_WAIT-th stalled cycle +1; flag stays after gnt_en=1 and grant.
REQ-034 SHALL test mid-operation reset: req=4'b1111, reset=1 for 1 cycle during GRANT -> next cycle gnt=0, starve=0; first post-reset grant=4'b0001.
REQ-035 SHALL run random req/gnt_en with assertions: one-hot gnt, gnt implies prior-cycle req, and with gnt_en=1 every req[i] granted within N_REQ cycles.
